// File: rtl/sram_result_ctrl.sv
// Initiator-side controller for the 128K x 16 result SRAM: streams a write job
// into consecutive addresses and reads a programmed range back out with backpressure.
module sram_result_ctrl #(
  parameter int AW = 17,
  parameter int DW = 16,
  parameter int CW = 18
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Wr_Start,
  input  logic [AW-1:0] Wr_Base,
  input  logic [CW-1:0] Wr_Count,
  input  logic          Rd_Start,
  input  logic [AW-1:0] Rd_Base,
  input  logic [CW-1:0] Rd_Count,
  input  logic          In_Valid,
  output logic          In_Ready,
  input  logic [DW-1:0] In_Data,
  output logic          Out_Valid,
  input  logic          Out_Ready,
  output logic [DW-1:0] Out_Data,
  output logic          Busy,
  output logic          Done,
  output logic [AW-1:0] Sram_Addr,
  output logic          Sram_RW,
  output logic          Sram_En,
  output logic [DW-1:0] Sram_Din,
  input  logic [DW-1:0] Sram_Dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ_REQ,
    S_READ_WAIT,
    S_READ_HOLD
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_rem;
  logic [DW-1:0] r_out_data;
  logic          r_out_valid;
  logic          r_done;
  logic          w_wr_hs;
  logic          w_rd_hs;

  assign w_wr_hs = (r_state == S_WRITE) && In_Valid;
  assign w_rd_hs = (r_state == S_READ_HOLD) && r_out_valid && Out_Ready;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // A zero-length job never leaves IDLE; only the Done pulse reports it.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (Wr_Start)      w_next = (Wr_Count == '0) ? S_IDLE : S_WRITE;
        else if (Rd_Start) w_next = (Rd_Count == '0) ? S_IDLE : S_READ_REQ;
      end
      S_WRITE:     if (w_wr_hs && r_rem == CW'(1)) w_next = S_IDLE;
      S_READ_REQ:  w_next = S_READ_WAIT;
      S_READ_WAIT: w_next = S_READ_HOLD;
      S_READ_HOLD: if (w_rd_hs) w_next = (r_rem != '0) ? S_READ_REQ : S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    In_Ready  = (r_state == S_WRITE);
    Busy      = (r_state != S_IDLE);
    Sram_En   = w_wr_hs || (r_state == S_READ_REQ);
    Sram_RW   = w_wr_hs;
    Sram_Addr = '0;
    Sram_Din  = '0;
    if (w_wr_hs) begin
      Sram_Addr = r_wr_ptr;
      Sram_Din  = In_Data;
    end else if (r_state == S_READ_REQ) begin
      Sram_Addr = r_rd_ptr;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rem       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Wr_Start) begin
            r_wr_ptr <= Wr_Base;
            r_rem    <= Wr_Count;
            r_done   <= (Wr_Count == '0);
          end else if (Rd_Start) begin
            r_rd_ptr <= Rd_Base;
            r_rem    <= Rd_Count;
            r_done   <= (Rd_Count == '0);
          end
        end
        S_WRITE: begin
          if (w_wr_hs) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            r_rem    <= r_rem - CW'(1);
            r_done   <= (r_rem == CW'(1));
          end
        end
        S_READ_WAIT: begin
          r_out_data  <= Sram_Dout;
          r_out_valid <= 1'b1;
          r_rd_ptr    <= r_rd_ptr + AW'(1);
          r_rem       <= r_rem - CW'(1);
        end
        S_READ_HOLD: begin
          if (w_rd_hs) begin
            r_out_valid <= 1'b0;
            r_done      <= (r_rem == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign Out_Valid = r_out_valid;
  assign Out_Data  = r_out_data;
  assign Done      = r_done;

endmodule

// File: tb/tb_sram_result_ctrl.sv
// Self-checking bench for sram_result_ctrl: behavioural SRAM plus an expected
// memory image built from the words the bench itself streams in.
module tb_sram_result_ctrl;
  localparam int AW = 17;
  localparam int DW = 16;
  localparam int CW = 18;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          Wr_Start, Rd_Start;
  logic [AW-1:0] Wr_Base, Rd_Base;
  logic [CW-1:0] Wr_Count, Rd_Count;
  logic          In_Valid, In_Ready;
  logic [DW-1:0] In_Data;
  logic          Out_Valid, Out_Ready;
  logic [DW-1:0] Out_Data;
  logic          Busy, Done;
  logic [AW-1:0] Sram_Addr;
  logic          Sram_RW, Sram_En;
  logic [DW-1:0] Sram_Din, Sram_Dout;

  logic [DW-1:0] sramMem [0:(1<<AW)-1];
  logic [DW-1:0] expMem  [0:(1<<AW)-1];
  int passCount  = 0;
  int checkCount = 0;
  int failCount  = 0;

  sram_result_ctrl #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .Clk(Clk), .Rst(Rst),
    .Wr_Start(Wr_Start), .Wr_Base(Wr_Base), .Wr_Count(Wr_Count),
    .Rd_Start(Rd_Start), .Rd_Base(Rd_Base), .Rd_Count(Rd_Count),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Data(In_Data),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Data(Out_Data),
    .Busy(Busy), .Done(Done),
    .Sram_Addr(Sram_Addr), .Sram_RW(Sram_RW), .Sram_En(Sram_En),
    .Sram_Din(Sram_Din), .Sram_Dout(Sram_Dout)
  );

  always #5 Clk = ~Clk;

  // Registered-output SRAM: read data appears the cycle after the strobe.
  always @(posedge Clk) begin
    if (Sram_En) begin
      if (Sram_RW) sramMem[Sram_Addr] <= Sram_Din;
      else         Sram_Dout <= sramMem[Sram_Addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // mode 0: valid every cycle with 0x1111*n data; 1: valid pattern 1,0,0,1; 2: random.
  task automatic applyStimulus(input logic [AW-1:0] base, input int count, input int mode,
                               input logic alsoRd);
    logic [AW-1:0] ptr;
    int left, cyc;
    logic v;
    Wr_Base = base; Wr_Count = CW'(count); Wr_Start = 1'b1;
    Rd_Base = base; Rd_Count = CW'(1);     Rd_Start = alsoRd;
    tick();
    Wr_Start = 1'b0; Rd_Start = 1'b0;
    ptr = base; left = count; cyc = 0;
    while (left > 0 && cyc < 200) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: v = 1'($urandom_range(0, 1));
      endcase
      In_Valid = v;
      In_Data  = (mode == 0) ? DW'(16'h1111 * (count - left + 1)) : DW'($urandom);
      @(negedge Clk);
      checkOutput("wr_busy", Busy, 1);
      checkOutput("wr_ready", In_Ready, 1);
      checkOutput("wr_done_low", Done, 0);
      checkOutput("wr_en", Sram_En, v);
      if (v) begin
        checkOutput("wr_rw", Sram_RW, 1);
        checkOutput("wr_addr", Sram_Addr, ptr);
        checkOutput("wr_din", Sram_Din, In_Data);
        expMem[ptr] = In_Data;
        ptr++;
        left--;
      end
      tick();
      cyc++;
    end
    checkOutput("wr_timeout", left, 0);
    In_Valid = 1'b0;
    @(negedge Clk);
    checkOutput("wr_done", Done, 1);
    checkOutput("wr_busy_end", Busy, 0);
    checkOutput("wr_ready_end", In_Ready, 0);
    checkOutput("wr_en_end", Sram_En, 0);
    tick();
    @(negedge Clk);
    checkOutput("wr_done_once", Done, 0);
    checkOutput("wr_no_read", Busy, 0);
    tick();
  endtask

  task automatic readJob(input logic [AW-1:0] base, input int count, input int stallWord,
                         input int stallLen);
    logic [AW-1:0] ptr;
    logic [DW-1:0] held;
    int lat, en;
    Rd_Base = base; Rd_Count = CW'(count); Rd_Start = 1'b1; Out_Ready = 1'b1;
    tick();
    Rd_Start = 1'b0;
    ptr = base;
    for (int w = 0; w < count; w++) begin
      Out_Ready = (w == stallWord) ? 1'b0 : 1'b1;
      lat = 0; en = 0;
      while (1) begin
        @(negedge Clk);
        if (Sram_En) begin
          checkOutput("rd_rw", Sram_RW, 0);
          checkOutput("rd_addr", Sram_Addr, ptr);
          en++;
        end
        if (Out_Valid || lat > 8) break;
        tick();
        lat++;
      end
      checkOutput("rd_latency", lat, 2);
      checkOutput("rd_strobes", en, 1);
      checkOutput("rd_data", Out_Data, expMem[ptr]);
      held = Out_Data;
      if (w == stallWord) begin
        repeat (stallLen) begin
          tick();
          @(negedge Clk);
          checkOutput("bp_valid", Out_Valid, 1);
          checkOutput("bp_data", Out_Data, held);
          checkOutput("bp_no_en", Sram_En, 0);
        end
        Out_Ready = 1'b1;
      end
      tick();
      ptr++;
    end
    @(negedge Clk);
    checkOutput("rd_done", Done, 1);
    checkOutput("rd_busy_end", Busy, 0);
    checkOutput("rd_valid_end", Out_Valid, 0);
    tick();
    @(negedge Clk);
    checkOutput("rd_done_once", Done, 0);
    tick();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, Out_Valid, 0);
    checkOutput({tag, "_data"}, Out_Data, 0);
    checkOutput({tag, "_done"}, Done, 0);
    checkOutput({tag, "_busy"}, Busy, 0);
    checkOutput({tag, "_inready"}, In_Ready, 0);
    checkOutput({tag, "_en"}, Sram_En, 0);
    checkOutput({tag, "_rw"}, Sram_RW, 0);
    checkOutput({tag, "_addr"}, Sram_Addr, 0);
    checkOutput({tag, "_din"}, Sram_Din, 0);
  endtask

  initial begin
    logic [AW-1:0] rb;
    int rc;
    Rst = 1'b0; Wr_Start = 0; Rd_Start = 0; Wr_Base = '0; Rd_Base = '0;
    Wr_Count = '0; Rd_Count = '0; In_Valid = 0; In_Data = '0; Out_Ready = 0;
    #1;
    checkAllZero("reset");
    tick(); tick();
    Rst = 1'b1;
    tick();

    applyStimulus(17'h00010, 4, 0, 1'b0);
    readJob(17'h00010, 4, -1, 0);

    applyStimulus(17'h1FFFE, 3, 2, 1'b0);
    readJob(17'h1FFFE, 3, 1, 5);

    applyStimulus(17'h00200, 6, 1, 1'b0);
    readJob(17'h00200, 6, 2, 5);

    applyStimulus(17'h00300, 2, 0, 1'b1);
    readJob(17'h00300, 2, -1, 0);

    Wr_Count = '0; Wr_Start = 1'b1;
    tick();
    Wr_Start = 1'b0;
    @(negedge Clk);
    checkOutput("wr0_done", Done, 1);
    checkOutput("wr0_busy", Busy, 0);
    checkOutput("wr0_en", Sram_En, 0);
    tick();
    @(negedge Clk);
    checkOutput("wr0_done_once", Done, 0);
    Rd_Count = '0; Rd_Start = 1'b1;
    tick();
    Rd_Start = 1'b0;
    @(negedge Clk);
    checkOutput("rd0_done", Done, 1);
    checkOutput("rd0_en", Sram_En, 0);
    checkOutput("rd0_valid", Out_Valid, 0);
    tick();

    Rd_Base = 17'h00010; Rd_Count = CW'(4); Rd_Start = 1'b1; Out_Ready = 1'b0;
    tick();
    Rd_Start = 1'b0;
    tick(); tick();
    checkOutput("abort_pre_valid", Out_Valid, 1);
    #2 Rst = 1'b0;
    #1;
    checkAllZero("abort");
    tick();
    checkOutput("abort_no_done", Done, 0);
    Rst = 1'b1;
    tick();
    @(negedge Clk);
    checkOutput("abort_no_done_after", Done, 0);
    tick();
    readJob(17'h00010, 4, -1, 0);

    for (int i = 0; i < 3; i++) begin
      rb = AW'($urandom);
      rc = $urandom_range(1, 5);
      applyStimulus(rb, rc, 2, 1'b0);
      readJob(rb, rc, $urandom_range(0, rc - 1), $urandom_range(1, 4));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
